// File: rtl/nois_setup_v2_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED output PIO.
// Address, strobes and write data flow master->slave; readdata returns.
interface nois_setup_v2_led_pio_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nois_setup_v2_led_pio.sv
// LED output PIO with a hardware blink engine (DATA/MASK/PERIOD/STATUS).
// Define LED_PIO_SETCLR_EN to make offset 3 writes an atomic DATA set/clear.
module nois_setup_v2_led_pio #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    nois_setup_v2_led_pio_if.slave bus,
    output logic [WIDTH-1:0]      out_port
);

    typedef enum logic {
        PH0 = 1'b0,
        PH1 = 1'b1
    } phase_e;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_MASK   = 2'd1;
    localparam logic [1:0] A_PERIOD = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           phase_q, phase_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic wr;
    logic sel_data;
    logic sel_mask;
    logic sel_period;
    logic sel_status;
    logic unused_wdata;

    assign wr = bus.chipselect & ~bus.write_n;

    assign sel_data   = wr && (bus.address == A_DATA);
    assign sel_mask   = wr && (bus.address == A_MASK);
    assign sel_period = wr && (bus.address == A_PERIOD);
    assign sel_status = wr && (bus.address == A_STATUS);

    assign unused_wdata = ^{bus.writedata, sel_status};

    always_comb begin
        data_d   = data_q;
        mask_d   = mask_q;
        period_d = period_q;
        unique case (1'b1)
            sel_data:   data_d   = bus.writedata[WIDTH-1:0];
            sel_mask:   mask_d   = bus.writedata[WIDTH-1:0];
            sel_period: period_d = bus.writedata[CNT_W-1:0];
`ifdef LED_PIO_SETCLR_EN
            sel_status: begin
                if (bus.writedata[31]) begin
                    data_d = data_q & ~bus.writedata[WIDTH-1:0];
                end else begin
                    data_d = data_q | bus.writedata[WIDTH-1:0];
                end
            end
`endif
            default: ;
        endcase
    end

    // A PERIOD write restarts the engine and beats a coincident wrap.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (sel_period || (period_q == '0)) begin
            cnt_d   = '0;
            phase_d = PH0;
        end else if (cnt_q == period_q - CNT_ONE) begin
            cnt_d = '0;
            unique case (phase_q)
                PH0:     phase_d = PH1;
                PH1:     phase_d = PH0;
                default: phase_d = PH0;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        out_d = data_q & ~(mask_q & {WIDTH{phase_q == PH1}});
    end

    always_comb begin
        readdata_d = '0;
        unique case (bus.address)
            A_DATA:   readdata_d[WIDTH-1:0] = data_q;
            A_MASK:   readdata_d[WIDTH-1:0] = mask_q;
            A_PERIOD: readdata_d[CNT_W-1:0] = period_q;
            A_STATUS: begin
                readdata_d[CNT_W-1:0] = cnt_q;
                readdata_d[31]        = (phase_q == PH1);
            end
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q     <= '0;
            mask_q     <= '0;
            period_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= PH0;
            readdata_q <= '0;
            out_q      <= '0;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            readdata_q <= readdata_d;
            out_q      <= out_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = out_q;

endmodule

// File: tb/tb_nois_setup_v2_led_pio.sv
// Scoreboard bench for the LED PIO: expectations are queued when stimulus
// is driven and compared at the following falling edge.
module tb_nois_setup_v2_led_pio;

    logic       clk;
    logic       reset_n;
    logic [9:0] out_port;

    nois_setup_v2_led_pio_if bus ();

    nois_setup_v2_led_pio #(
        .WIDTH (10),
        .CNT_W (24)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    string       tag_q[$];
    logic [32:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit is_rd,
                        input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back({is_rd, exp});
    endtask

    task automatic flush();
        string       t;
        logic [32:0] e;
        logic [31:0] o;
        while (exp_q.size() > 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            o = '0;
            if (e[32]) o = bus.readdata;
            else o[9:0] = out_port;
            chk(t, o, e[31:0]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        flush();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
    endtask

    task automatic idle(input logic [1:0] a);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = a;
        bus.writedata  = 32'h0;
    endtask

    function automatic logic [31:0] stat(input int k, input int per);
        logic [31:0] v;
        v     = 32'(k % per);
        v[31] = ((k / per) % 2) == 1;
        return v;
    endfunction

    function automatic logic [31:0] led(input int k, input int per);
        return (((k / per) % 2) == 1) ? 32'h3F0 : 32'h3FF;
    endfunction

    logic [31:0] e1;
    logic [31:0] e2;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        idle(2'd0);
        repeat (2) @(negedge clk);
        push("rst_rd", 1, 32'h0);
        push("rst_out", 0, 32'h0);
        flush();
        reset_n = 1'b1;

        for (int a = 0; a < 4; a++) begin
            idle(2'(a));
            push($sformatf("rd0_off%0d", a), 1, 32'h0);
            push("rd0_out", 0, 32'h0);
            step();
        end

        wr(2'd0, 32'hFFFF_F2A5);
        push("data_e1", 0, 32'h0);
        step();
        idle(2'd0);
        push("data_e2", 0, 32'h2A5);
        step();
        push("data_hold", 0, 32'h2A5);
        push("data_rd", 1, 32'h2A5);
        step();

        wr(2'd0, 32'h3FF);
        push("d3ff_out", 0, 32'h2A5);
        step();
        wr(2'd1, 32'hFFFF_F00F);
        push("mask_out", 0, 32'h3FF);
        step();
        idle(2'd1);
        push("mask_rd", 1, 32'h00F);
        step();

        wr(2'd2, 32'd4);
        push("per4_rd", 1, 32'h0);
        push("per4_out", 0, 32'h3FF);
        step();
        idle(2'd3);
        for (int k = 0; k < 6; k++) begin
            push($sformatf("p4_st%0d", k), 1, stat(k, 4));
            push($sformatf("p4_led%0d", k), 0, led(k, 4));
            step();
        end

        wr(2'd2, 32'd2);
        push("per2_rd", 1, 32'd4);
        push("per2_out", 0, 32'h3F0);
        step();
        idle(2'd3);
        for (int m = 0; m < 8; m++) begin
            push($sformatf("p2_st%0d", m), 1, stat(m, 2));
            push($sformatf("p2_led%0d", m), 0, led(m, 2));
            step();
        end
        idle(2'd2);
        push("per2_rdback", 1, 32'd2);
        step();

        #2;
        reset_n = 1'b0;
        #1;
        push("arst_rd", 1, 32'h0);
        push("arst_out", 0, 32'h0);
        flush();
        @(negedge clk);
        reset_n = 1'b1;
        idle(2'd3);
        for (int i = 0; i < 4; i++) begin
            push("post_st", 1, 32'h0);
            push("post_out", 0, 32'h0);
            step();
        end

        wr(2'd0, 32'h3FF);
        push("re_d_out", 0, 32'h0);
        step();
        wr(2'd1, 32'h00F);
        push("re_m_out", 0, 32'h3FF);
        step();
        idle(2'd3);
        for (int i = 0; i < 6; i++) begin
            push("noblink_st", 1, 32'h0);
            push("noblink_out", 0, 32'h3FF);
            step();
        end

`ifdef LED_PIO_SETCLR_EN
        e1 = 32'h0F3;
        e2 = 32'h0C3;
`else
        e1 = 32'h0F0;
        e2 = 32'h0F0;
`endif
        wr(2'd0, 32'h0F0);
        push("sc_d_out", 0, 32'h3FF);
        step();
        wr(2'd3, 32'h0000_0003);
        push("sc_pre_out", 0, 32'h0F0);
        step();
        idle(2'd0);
        push("sc_set_rd", 1, e1);
        push("sc_set_out", 0, e1);
        step();
        wr(2'd3, 32'h8000_0030);
        push("sc_clr_pre", 0, e1);
        step();
        idle(2'd0);
        push("sc_clr_rd", 1, e2);
        push("sc_clr_out", 0, e2);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nois_setup_v2_led_pio.md
Name: nois_setup_v2_led_pio

Overview:
- Avalon-MM slave output PIO that drives board LEDs from the Nios II.
- It is the write-side counterpart to the system's input button PIO.
- Holds a software-written data register and adds a hardware blink engine, so selected outputs flash at a programmable rate with no CPU load.
- Sits on the Nios II data master bus; out_port goes to the LED pins.

Parameters:
- WIDTH, 10, number of output bits (1..32).
- CNT_W, 24, width of the half-period register and blink counter (1..31).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  Avalon register select (word offset).
- chipselect  input  1  Avalon slave select.
- write_n  input  1  Avalon write strobe, active-low.
- writedata  input  32  Avalon write data.
- readdata  output  32  Avalon read data, registered.
- out_port  output  WIDTH  LED drive, registered.

Behaviour:
- Clock and reset: one clock, clk; reset_n is asynchronous, active-low.
- Reset values: all outputs and registers are 0, including readdata, out_port, DATA, MASK, PERIOD, cnt and phase.
- Write strobe: wr = chipselect & ~write_n, sampled on the rising edge of clk. There are no wait states.
- Register map:
  - Offset 0, DATA (R/W): writedata[WIDTH-1:0]; upper bits ignored.
  - Offset 1, MASK (R/W): blink-enable per bit, writedata[WIDTH-1:0].
  - Offset 2, PERIOD (R/W): half-period in clocks, writedata[CNT_W-1:0]. Any write clears cnt and phase to 0 on the same edge.
  - Offset 3, STATUS (read): {phase at bit 31, zeros, cnt[CNT_W-1:0]}. Write behaviour depends on the optional feature.
- Read: readdata is registered every clock from a mux on address, regardless of chipselect, giving read latency 1. Unused bits read 0. Reads have no side effects.
- Blink engine, two states PH0/PH1 held in phase:
  - PERIOD == 0: cnt is held at 0 and phase at 0 (blink off).
  - PERIOD != 0: each clock, if cnt == PERIOD-1 then cnt <= 0 and phase toggles; otherwise cnt <= cnt + 1.
  - The counter wraps at PERIOD-1 and never reaches PERIOD. Toggle interval = PERIOD clocks.
  - Special case PERIOD == 1: phase toggles every clock.
- Output: out_port <= DATA & ~(MASK & {WIDTH{phase}}), evaluated every clock.
  - Masked bits show DATA in PH0 and are forced to 0 in PH1.
  - A DATA write at edge k appears on out_port at edge k+1.
- Simultaneous events:
  - A PERIOD write coincident with a wrap: the write wins (cnt = 0, phase = 0).
  - A MASK write mid-period does not disturb cnt or phase.
  - Writing PERIOD smaller than the current cnt is safe, because the write clears cnt.
- Reset mid-blink: everything returns to 0 immediately and asynchronously; out_port goes to 0.

Optional Feature:
- Macro: LED_PIO_SETCLR_EN.
- Defined: a write to offset 3 is an atomic bit set/clear on DATA.
  - writedata[31] = 0: DATA <= DATA | writedata[WIDTH-1:0].
  - writedata[31] = 1: DATA <= DATA & ~writedata[WIDTH-1:0].
  - Same-edge timing as a DATA write.
- Undefined: writes to offset 3 are ignored, and the set/clear logic is not synthesised.
- STATUS reads are identical in both cases.

Test Plan:
- Reset, then read offsets 0-3: readdata = 0 one cycle after each address; out_port = 0.
- Write DATA = 0x2A5 with PERIOD = 0: out_port = 0x2A5 from the second edge after the write and stays there; read DATA returns 0x000002A5.
- DATA = 0x3FF, MASK = 0x00F, PERIOD = 4: out_port alternates 0x3FF / 0x3F0 every 4 clocks. STATUS shows cnt stepping 0, 1, 2, 3, 0 and bit 31 toggling at each wrap.
- Mid-blink (phase = 1, cnt = 2), write PERIOD = 2: on the next edge cnt = 0 and phase = 0, and out_port returns to 0x3FF. The toggle period becomes 2 clocks.
- Assert reset_n low asynchronously mid-blink: out_port and readdata drop to 0 without a clock edge. After release, blinking stays off until PERIOD is rewritten.
- With LED_PIO_SETCLR_EN, DATA = 0x0F0:
  - Write 0x00000003 to offset 3: DATA = 0x0F3.
  - Write 0x80000030 to offset 3: DATA = 0x0C3.
  - Without the macro, DATA stays 0x0F0.
